// File: rtl/freq_readback_regbank_if.sv
// freq_readback_regbank_if: MCU parallel read bus between the bus master and the read-back register bank
interface freq_readback_regbank_if;
   logic        cs;
   logic        rd;
   logic [15:0] addr;
   logic [15:0] rd_data;
   logic        rd_valid;
   logic        irq;
   modport master (output cs, rd, addr, input rd_data, rd_valid, irq);
   modport slave  (input cs, rd, addr, output rd_data, rd_valid, irq);
endinterface

// File: rtl/freq_readback_regbank.sv
// freq_readback_regbank: per-channel result capture with tear-free 16-bit MCU read-back, new/overrun flags and IRQ
module freq_readback_regbank #(
   parameter int          NUM_CH      = 4,
   parameter int          DATA_W      = 32,
   parameter logic [15:0] BASE_ADDR   = 16'h0002,
   parameter int          SYNC_STAGES = 2
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   freq_readback_regbank_if.slave   bus,
   input  logic [NUM_CH*DATA_W-1:0] i_ch_data,
   input  logic [NUM_CH-1:0]        i_ch_valid
);
   logic [SYNC_STAGES-1:0] r_cs_sync;
   logic [SYNC_STAGES-1:0] r_rd_sync;
   logic                   r_act;
   logic                   r_act_d;
   logic [DATA_W-1:0]      r_cap [NUM_CH];
   logic [15:0]            r_snap [NUM_CH];
   logic [NUM_CH-1:0]      r_lock;
   logic [NUM_CH-1:0]      r_new;
   logic [NUM_CH-1:0]      r_ovr;
   logic [15:0]            r_rd_data;
   logic                   r_rd_valid;
   logic                   r_irq;
   logic                   w_evt;
   logic                   w_ovr_rd;
   logic [15:0]            w_off;
   logic [15:0]            w_rdata;
   logic [31:0]            w_ext;
   logic [NUM_CH-1:0]      w_hi_rd;
   logic [NUM_CH-1:0]      w_lo_rd;
   assign w_evt    = r_act & ~r_act_d;
   assign w_off    = bus.addr - BASE_ADDR;
   assign w_ovr_rd = w_evt & (w_off == 16'(2*NUM_CH+1));
   always_comb begin
      w_rdata = '0;
      w_ext   = '0;
      w_hi_rd = '0;
      w_lo_rd = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         w_ext      = 32'(r_cap[k]);
         w_hi_rd[k] = w_evt & (w_off == 16'(2*k));
         w_lo_rd[k] = w_evt & (w_off == 16'(2*k+1));
         w_rdata    = (w_off == 16'(2*k))   ? w_ext[31:16] :
                      (w_off == 16'(2*k+1)) ? (r_lock[k] ? r_snap[k] : w_ext[15:0]) : w_rdata;
      end
      w_rdata = (w_off == 16'(2*NUM_CH))   ? 16'(r_new) :
                (w_off == 16'(2*NUM_CH+1)) ? 16'(r_ovr) : w_rdata;
   end
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_cs_sync  <= '1;
         r_rd_sync  <= '0;
         r_act      <= 1'b0;
         r_act_d    <= 1'b0;
         r_lock     <= '0;
         r_new      <= '0;
         r_ovr      <= '0;
         r_rd_data  <= '0;
         r_rd_valid <= 1'b0;
         r_irq      <= 1'b0;
         for (int k = 0; k < NUM_CH; k++) begin
            r_cap[k]  <= '0;
            r_snap[k] <= '0;
         end
      end else begin
         r_cs_sync  <= {r_cs_sync[SYNC_STAGES-2:0], bus.cs};
         r_rd_sync  <= {r_rd_sync[SYNC_STAGES-2:0], bus.rd};
         r_act      <= ~r_cs_sync[SYNC_STAGES-1] & r_rd_sync[SYNC_STAGES-1];
         r_act_d    <= r_act;
         r_rd_valid <= w_evt;
         r_irq      <= |r_new;
         if (w_evt) r_rd_data <= w_rdata;
         for (int k = 0; k < NUM_CH; k++) begin
            if (i_ch_valid[k]) r_cap[k] <= i_ch_data[k*DATA_W +: DATA_W];
            if (w_hi_rd[k]) r_snap[k] <= r_cap[k][15:0];
            r_lock[k] <= w_hi_rd[k] | (r_lock[k] & ~w_lo_rd[k]);
            r_new[k]  <= i_ch_valid[k] | (r_new[k] & ~w_lo_rd[k]);
            r_ovr[k]  <= (i_ch_valid[k] & r_new[k] & ~w_lo_rd[k]) | (r_ovr[k] & ~w_ovr_rd);
         end
      end
   end
   assign bus.rd_data  = r_rd_data;
   assign bus.rd_valid = r_rd_valid;
   assign bus.irq      = r_irq;
endmodule

// File: tb/tb_freq_readback_regbank.sv
// tb_freq_readback_regbank: directed and random bus reads checked against a behavioural register-bank model
module tb_freq_readback_regbank;
   localparam int          N = 4;
   localparam int          W = 32;
   localparam int          S = 2;
   localparam logic [15:0] A = 16'h0002;
   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic [N*W-1:0] ch_data = '0;
   logic [N-1:0]   ch_valid = '0;
   int             tests = 0;
   int             fails = 0;
   int             pulses = 0;
   int             p0;
   logic [31:0]    m_cap [N];
   logic [15:0]    m_snap [N];
   logic [N-1:0]   m_lock, m_new, m_ovr;
   freq_readback_regbank_if bus();
   freq_readback_regbank #(.NUM_CH(N), .DATA_W(W), .BASE_ADDR(A), .SYNC_STAGES(S)) dut (
      .i_clk(clk), .i_rst(rst), .bus(bus), .i_ch_data(ch_data), .i_ch_valid(ch_valid));
   always #5 clk = ~clk;
   always @(posedge clk) if (bus.rd_valid === 1'b1) pulses++;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic m_reset();
      for (int k = 0; k < N; k++) begin
         m_cap[k] = '0;
         m_snap[k] = '0;
      end
      m_lock = '0;
      m_new = '0;
      m_ovr = '0;
   endtask
   function automatic logic [15:0] m_read(input logic [15:0] a);
      int o;
      int k;
      logic [15:0] r;
      o = int'(a) - int'(A);
      r = 16'h0000;
      if (o >= 0 && o < 2*N) begin
         k = o / 2;
         if (o % 2 == 0) begin
            r = m_cap[k][31:16];
            m_snap[k] = m_cap[k][15:0];
            m_lock[k] = 1'b1;
         end else begin
            r = m_lock[k] ? m_snap[k] : m_cap[k][15:0];
            m_lock[k] = 1'b0;
            m_new[k] = 1'b0;
         end
      end else if (o == 2*N) r = 16'(m_new);
      else if (o == 2*N+1) begin
         r = 16'(m_ovr);
         m_ovr = '0;
      end
      return r;
   endfunction
   function automatic void m_valid(input int k, input logic [31:0] d);
      if (m_new[k]) m_ovr[k] = 1'b1;
      m_new[k] = 1'b1;
      m_cap[k] = d;
   endfunction
   task automatic pulse_valid(input int k, input logic [31:0] d);
      @(negedge clk);
      ch_data[k*W +: W] = d;
      ch_valid[k] = 1'b1;
      @(negedge clk);
      ch_valid = '0;
      m_valid(k, d);
      @(posedge clk);
      #1 check("irq_after_valid", bus.irq, 1);
   endtask
   task automatic bus_read(input logic [15:0] a, input string tag, input logic [N-1:0] sv = '0, input logic [31:0] sd = '0);
      logic [15:0] exp;
      int lat;
      exp = m_read(a);
      for (int k = 0; k < N; k++) if (sv[k]) begin
         ch_data[k*W +: W] = sd;
         m_valid(k, sd);
      end
      @(negedge clk);
      bus.addr = a;
      bus.cs = 1'b0;
      bus.rd = 1'b1;
      lat = 0;
      for (int i = 1; i <= 20 && lat == 0; i++) begin
         @(posedge clk);
         #1;
         ch_valid = (i == S+1) ? sv : '0;
         if (bus.rd_valid === 1'b1) lat = i;
      end
      ch_valid = '0;
      check({tag, "_lat"}, lat, S+2);
      check(tag, bus.rd_data, exp);
      @(posedge clk);
      #1 check({tag, "_pulse"}, bus.rd_valid, 0);
      bus.rd = 1'b0;
      bus.cs = 1'b1;
      repeat (S+3) @(posedge clk);
      #1 check({tag, "_hold"}, bus.rd_data, exp);
      check({tag, "_irq"}, bus.irq, |m_new);
   endtask
   initial begin
      bus.cs = 1'b1;
      bus.rd = 1'b0;
      bus.addr = '0;
      m_reset();
      repeat (3) @(posedge clk);
      #1 check("rst_rd_data", bus.rd_data, 0);
      check("rst_rd_valid", bus.rd_valid, 0);
      check("rst_irq", bus.irq, 0);
      @(negedge clk) rst = 1'b0;
      for (int a = 0; a < 2*N+2; a++) bus_read(A + 16'(a), "t1_read");
      check("t1_pulses", pulses, 2*N+2);
      pulse_valid(1, 32'h1234_5678);
      bus_read(A + 16'(2*N), "t2_new_set");
      bus_read(A + 16'd2, "t2_hi");
      bus_read(A + 16'd3, "t2_lo");
      bus_read(A + 16'(2*N), "t2_new_clr");
      check("t2_irq_clr", bus.irq, 0);
      pulse_valid(0, 32'hAAAA_BBBB);
      bus_read(A, "t3_hi");
      pulse_valid(0, 32'hCCCC_DDDD);
      bus_read(A + 16'd1, "t3_snap");
      bus_read(A + 16'd1, "t3_live");
      bus_read(A + 16'(2*N+1), "t4_preclr");
      pulse_valid(2, 32'h0000_0001);
      pulse_valid(2, 32'h0000_0002);
      bus_read(A + 16'(2*N+1), "t4_ovr");
      bus_read(A + 16'(2*N+1), "t4_ovr_clr");
      pulse_valid(3, 32'h1111_2222);
      bus_read(A + 16'd7, "t5_simul", 4'b1000, 32'h3333_4444);
      bus_read(A + 16'(2*N), "t5_new");
      bus_read(A + 16'(2*N+1), "t5_no_ovr");
      bus_read(A + 16'd7, "t5_newlow");
      @(negedge clk);
      bus.addr = A + 16'd2;
      bus.cs = 1'b0;
      bus.rd = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      p0 = pulses;
      m_reset();
      #1 check("t6_rd_data", bus.rd_data, 0);
      check("t6_rd_valid", bus.rd_valid, 0);
      check("t6_irq", bus.irq, 0);
      bus.cs = 1'b1;
      bus.rd = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk) rst = 1'b0;
      repeat (S+4) @(posedge clk);
      check("t6_no_pulse", pulses, p0);
      bus_read(16'h00FF, "t6_unmapped");
      bus_read(A + 16'(2*N), "t6_flags");
      for (int i = 0; i < 150; i++) begin
         if ($urandom_range(0, 2) == 0) pulse_valid(int'($urandom_range(0, N-1)), $urandom);
         else bus_read(($urandom_range(0, 15) == 0) ? 16'hFFFF : 16'($urandom_range(A-1, A+2*N+2)), "rnd",
                       ($urandom_range(0, 3) == 0) ? N'(1 << $urandom_range(0, N-1)) : '0, $urandom);
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
